sq_qpn_scheduler: RTL and testbench
===================================

# sq_qpn_scheduler

Scheduler between the SQ doorbell path and the WQE fetch stage. It accepts QPNs from two requesters: new doorbells from the doorbell parser, and reschedules from the WQE fetch stage when a QP still has WQEs pending. It arbitrates round-robin into a circular schedule queue and presents one QPN at a time to WQE fetch. It owns the OnScheduleRecord write port: it clears the record after reset, sets bits on doorbell enqueue and clears them on deschedule.

## Interface
- QPN_LOG, 14: log2 of supported QP count; OnScheduleRecord address width.
- QUEUE_LOG, 4: log2 of schedule-queue depth (DEPTH = 2^QUEUE_LOG).
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- db_qpn_valid / db_qpn_data / db_qpn_ready  in/in/out  1/24/1  doorbell QPN stream.
- resched_valid / resched_qpn / resched_ready  in/in/out  1/24/1  reschedule stream from WQE fetch.
- desched_valid / desched_qpn / desched_ready  in/in/out  1/24/1  "QP drained" notification; clears the record bit.
- sched_valid / sched_qpn / sched_ready  out/out/in  1/24/1  scheduled QPN to WQE fetch.
- on_schedule_wen / on_schedule_addr / on_schedule_din  out/out/out  1/QPN_LOG/1  OnScheduleRecord write port.
- init_done  out  1  high once the record clear completes.

## Operation
- States: INIT_s, RUN_s.
- INIT_s is entered on reset.
  - Writes din=0 to addresses 0 .. 2^QPN_LOG-1, one per cycle, using a QPN_LOG+1-bit counter.
  - All *_ready outputs and sched_valid are held 0.
  - After the last address: RUN_s, init_done=1. The FSM never returns to INIT_s except via reset.
- RUN_s enqueue arbitration:
  - Candidates are db and resched. A candidate is eligible only when its valid is high and count < DEPTH.
  - With both eligible, grant goes to the side indicated by a 1-bit round-robin pointer. The pointer flips to the other side after every grant. Its reset value favours db.
  - At most one enqueue per cycle. Only the granted side sees ready=1.
- Doorbell grant:
  - Enqueues db_qpn_data.
  - Same cycle: on_schedule_wen=1, addr=db_qpn_data[QPN_LOG-1:0], din=1.
- Resched grant: enqueues resched_qpn. No record write; the bit is already set.
- Deschedule:
  - desched_ready=1 only when no doorbell grant occurs that cycle. The doorbell owns the write port.
  - On handshake: wen=1, addr=desched_qpn[QPN_LOG-1:0], din=0.
- Dequeue: sched_valid = (count != 0). sched_qpn = queue head. Handshake advances the read pointer.
- Queue: DEPTH x 24 register array, QUEUE_LOG-bit pointers with natural wrap, QUEUE_LOG+1-bit count.
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - Full (count==DEPTH): db_qpn_ready=resched_ready=0 even if a dequeue occurs that cycle.
- QPN bits above QPN_LOG are carried through the queue unchanged but ignored for addressing.

## Timing
- Reset values: all *_ready=0, sched_valid=0, sched_qpn=0, on_schedule_wen=1, on_schedule_addr=0, on_schedule_din=0, init_done=0.
- INIT length is exactly 2^QPN_LOG cycles after reset deassertion.
- Enqueue-to-sched_valid latency: 1 cycle (registered storage). No bypass when empty.
- Record write is combinational in the grant cycle. DBProc reading the same QPN on the next cycle sees 1.
- Reset mid-operation: queue contents are discarded, pointers and count go to 0, INIT restarts.
- Valid may drop without a handshake. Arbitration uses only the current cycle's eligibility.

## Configuration
- SCHED_STAT_EN defined: adds outputs stat_db_cnt[31:0], stat_resched_cnt[31:0] and stat_full_cyc[31:0].
  - stat_db_cnt and stat_resched_cnt count grants per source.
  - stat_full_cyc counts RUN_s cycles with count==DEPTH.
  - All three wrap at 2^32, are reset to 0 by rst and do not count during INIT_s.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- QPN_LOG=4: after reset, addr steps 0..15 with wen=1, din=0 over 16 cycles, then init_done=1 and db_qpn_ready can rise.
- Single doorbell 0x000005: record write to addr 5, din=1 in the grant cycle; sched_valid=1, sched_qpn=0x000005 the next cycle.
- db and resched held valid continuously with distinct QPNs, sched_ready=1: grants alternate db, resched, db, ...; output order matches.
- Fill 16 entries with sched_ready=0: both readies drop at count=16. One dequeue, then the next enqueue is accepted; pointers wrap to 0.
- Doorbell grant and desched_valid in the same cycle: desched_ready=0 and only the din=1 write occurs. Desched completes the following cycle with din=0.
- rst asserted with 5 entries queued: sched_valid=0 immediately and INIT restarts. With SCHED_STAT_EN defined, all counters read 0.

Source files
------------

// File: rtl/sq_qpn_scheduler_if.sv
// Bundle of the doorbell, reschedule, deschedule and schedule streams plus the
// OnScheduleRecord write port and init status of the SQ QPN scheduler.
// The slave modport is the scheduler side; master is the surrounding logic.
interface sq_qpn_scheduler_if #(
  parameter int QPN_LOG = 14
);
  logic               db_qpn_valid;
  logic [23:0]        db_qpn_data;
  logic               db_qpn_ready;

  logic               resched_valid;
  logic [23:0]        resched_qpn;
  logic               resched_ready;

  logic               desched_valid;
  logic [23:0]        desched_qpn;
  logic               desched_ready;

  logic               sched_valid;
  logic [23:0]        sched_qpn;
  logic               sched_ready;

  logic               on_schedule_wen;
  logic [QPN_LOG-1:0] on_schedule_addr;
  logic               on_schedule_din;

  logic               init_done;

  modport slave (
    input  db_qpn_valid, db_qpn_data,
    output db_qpn_ready,
    input  resched_valid, resched_qpn,
    output resched_ready,
    input  desched_valid, desched_qpn,
    output desched_ready,
    output sched_valid, sched_qpn,
    input  sched_ready,
    output on_schedule_wen, on_schedule_addr, on_schedule_din,
    output init_done
  );

  modport master (
    output db_qpn_valid, db_qpn_data,
    input  db_qpn_ready,
    output resched_valid, resched_qpn,
    input  resched_ready,
    output desched_valid, desched_qpn,
    input  desched_ready,
    input  sched_valid, sched_qpn,
    output sched_ready,
    input  on_schedule_wen, on_schedule_addr, on_schedule_din,
    input  init_done
  );
endinterface

// File: rtl/sq_qpn_scheduler.sv
// SQ QPN scheduler: clears the OnScheduleRecord after reset, then arbitrates
// doorbells and reschedules round-robin into a circular schedule queue and
// presents one QPN at a time to WQE fetch. Doorbell grants set the record
// bit, deschedules clear it; the doorbell always owns the write port.
// Optional macro SCHED_STAT_EN adds grant and queue-full statistics outputs.
module sq_qpn_scheduler #(
  parameter int QPN_LOG   = 14,
  parameter int QUEUE_LOG = 4
) (
  input  logic                clk,
  input  logic                rst,   // asynchronous, active-low
  sq_qpn_scheduler_if.slave   bus
`ifdef SCHED_STAT_EN
  ,
  output logic [31:0]         stat_db_cnt,
  output logic [31:0]         stat_resched_cnt,
  output logic [31:0]         stat_full_cyc
`else
  // Statistics ports are absent in this build.
`endif
);

  localparam int DEPTH = 1 << QUEUE_LOG;

  localparam logic [0:0] INIT_S = 1'b0;
  localparam logic [0:0] RUN_S  = 1'b1;

  localparam logic [QPN_LOG:0]   INIT_LAST = {1'b0, {QPN_LOG{1'b1}}};
  localparam logic [QUEUE_LOG:0] FULL_CNT  = {1'b1, {QUEUE_LOG{1'b0}}};

  logic [0:0]           state_q,    state_d;
  logic [QPN_LOG:0]     init_cnt_q, init_cnt_d;
  logic                 rr_q,       rr_d;      // 0: favour db, 1: favour resched
  logic [QUEUE_LOG-1:0] wr_ptr_q,   wr_ptr_d;
  logic [QUEUE_LOG-1:0] rd_ptr_q,   rd_ptr_d;
  logic [QUEUE_LOG:0]   count_q,    count_d;
  logic [23:0]          mem_q [DEPTH];

  logic        run;
  logic        full;
  logic        db_elig;
  logic        rs_elig;
  logic        grant_db;
  logic        grant_rs;
  logic        desched_fire;
  logic        enq;
  logic        deq;
  logic [23:0] enq_data;

  // Arbitration, handshakes, record write port and next-state computation.
  always_comb begin
    // NOTE: every signal gets a default up front so no path through this block
    // leaves one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    rr_d         = rr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    run          = (state_q == RUN_S);
    full         = (count_q == FULL_CNT);
    db_elig      = run && bus.db_qpn_valid  && !full;
    rs_elig      = run && bus.resched_valid && !full;
    grant_db     = db_elig && (!rs_elig || !rr_q);
    grant_rs     = rs_elig && !grant_db;
    desched_fire = run && !grant_db && bus.desched_valid;
    enq          = grant_db || grant_rs;
    enq_data     = grant_db ? bus.db_qpn_data : bus.resched_qpn;
    deq          = (count_q != '0) && bus.sched_ready;

    bus.db_qpn_ready  = grant_db;
    bus.resched_ready = grant_rs;
    bus.desched_ready = run && !grant_db;
    bus.sched_valid   = (count_q != '0);
    bus.init_done     = run;

    // The head slot is undefined while empty; show zero instead.
    bus.sched_qpn     = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

    bus.on_schedule_wen  = 1'b0;
    bus.on_schedule_addr = '0;
    bus.on_schedule_din  = 1'b0;

    if (!run) begin
      bus.on_schedule_wen  = 1'b1;
      bus.on_schedule_addr = init_cnt_q[QPN_LOG-1:0];
      bus.on_schedule_din  = 1'b0;
      init_cnt_d           = init_cnt_q + 1'b1;
      if (init_cnt_q == INIT_LAST) begin
        state_d = RUN_S;
      end
    end else if (grant_db) begin
      bus.on_schedule_wen  = 1'b1;
      bus.on_schedule_addr = bus.db_qpn_data[QPN_LOG-1:0];
      bus.on_schedule_din  = 1'b1;
    end else if (desched_fire) begin
      bus.on_schedule_wen  = 1'b1;
      bus.on_schedule_addr = bus.desched_qpn[QPN_LOG-1:0];
      bus.on_schedule_din  = 1'b0;
    end

    if (grant_db) begin
      rr_d = 1'b1;
    end else if (grant_rs) begin
      rr_d = 1'b0;
    end

    if (enq) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state: FSM, init counter, round-robin pointer, queue pointers.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    if (!rst) begin
      state_q    <= INIT_S;
      init_cnt_q <= '0;
      rr_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      rr_q       <= rr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage write.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; count and pointers decide
    // which slots are live, and the output masks the head while empty.
    if (enq) begin
      mem_q[wr_ptr_q] <= enq_data;
    end
  end

`ifdef SCHED_STAT_EN
  // Grant and queue-full statistics, counted only in RUN_S, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_db_cnt      <= '0;
      stat_resched_cnt <= '0;
      stat_full_cyc    <= '0;
    end else begin
      if (grant_db) begin
        stat_db_cnt <= stat_db_cnt + 32'd1;
      end
      if (grant_rs) begin
        stat_resched_cnt <= stat_resched_cnt + 32'd1;
      end
      if (run && full) begin
        stat_full_cyc <= stat_full_cyc + 32'd1;
      end
    end
  end
`else
  // No statistics counters in this build.
`endif

endmodule

// File: tb/tb_sq_qpn_scheduler.sv
// Directed self-checking bench for sq_qpn_scheduler with QPN_LOG=4,
// QUEUE_LOG=4. Inputs change on the falling edge; outputs are checked 1 ns
// later, well before the next rising edge.
module tb_sq_qpn_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sq_qpn_scheduler_if #(.QPN_LOG(4)) bus ();

`ifdef SCHED_STAT_EN
  logic [31:0] stat_db_cnt;
  logic [31:0] stat_resched_cnt;
  logic [31:0] stat_full_cyc;
`endif

  sq_qpn_scheduler #(
    .QPN_LOG   (4),
    .QUEUE_LOG (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus)
`ifdef SCHED_STAT_EN
    ,
    .stat_db_cnt      (stat_db_cnt),
    .stat_resched_cnt (stat_resched_cnt),
    .stat_full_cyc    (stat_full_cyc)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [23:0] exp_q [$];
  logic [23:0] prev_qpn;
  logic [23:0] head;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Checks the 16 INIT cycles; entered at falling edge + 1 ns right after
  // reset release, leaves at falling edge + 1 ns of the first RUN_s cycle.
  task automatic check_init();
    for (int i = 0; i < 16; i++) begin
      check("init_wen",   bus.on_schedule_wen,  1);
      check("init_addr",  bus.on_schedule_addr, i);
      check("init_din",   bus.on_schedule_din,  0);
      check("init_done0", bus.init_done,        0);
      check("init_dbrdy", bus.db_qpn_ready,     0);
      check("init_svld",  bus.sched_valid,      0);
      @(negedge clk); #1;
    end
    check("init_done1", bus.init_done, 1);
  endtask

  initial begin
    bus.db_qpn_valid  = 1'b1;
    bus.db_qpn_data   = 24'h000005;
    bus.resched_valid = 1'b0;
    bus.resched_qpn   = '0;
    bus.desched_valid = 1'b0;
    bus.desched_qpn   = '0;
    bus.sched_ready   = 1'b0;

    // Reset values
    #2;
    check("rst_dbrdy", bus.db_qpn_ready,     0);
    check("rst_rsrdy", bus.resched_ready,    0);
    check("rst_dsrdy", bus.desched_ready,    0);
    check("rst_svld",  bus.sched_valid,      0);
    check("rst_sqpn",  bus.sched_qpn,        0);
    check("rst_wen",   bus.on_schedule_wen,  1);
    check("rst_addr",  bus.on_schedule_addr, 0);
    check("rst_din",   bus.on_schedule_din,  0);
    check("rst_done",  bus.init_done,        0);

    @(negedge clk); rst = 1'b1; #1;
    check_init();

    // Single doorbell 0x000005: record write in grant cycle, visible next cycle
    check("db1_rdy",  bus.db_qpn_ready,     1);
    check("db1_wen",  bus.on_schedule_wen,  1);
    check("db1_addr", bus.on_schedule_addr, 5);
    check("db1_din",  bus.on_schedule_din,  1);
    check("db1_svld", bus.sched_valid,      0);
    @(negedge clk); bus.db_qpn_valid = 1'b0; #1;
    check("db1_svld2", bus.sched_valid,     1);
    check("db1_sqpn",  bus.sched_qpn,       24'h000005);
    check("db1_wen2",  bus.on_schedule_wen, 0);
    bus.sched_ready = 1'b1;

    // Lone reschedule: no record write; pointer returns to favouring db
    @(negedge clk);
    bus.sched_ready   = 1'b0;
    bus.resched_valid = 1'b1;
    bus.resched_qpn   = 24'h000007;
    #1;
    check("rs1_empty", bus.sched_valid,     0);
    check("rs1_rdy",   bus.resched_ready,   1);
    check("rs1_dbrdy", bus.db_qpn_ready,    0);
    check("rs1_wen",   bus.on_schedule_wen, 0);
    @(negedge clk); bus.resched_valid = 1'b0; bus.sched_ready = 1'b1; #1;
    check("rs1_svld", bus.sched_valid, 1);
    check("rs1_sqpn", bus.sched_qpn,   24'h000007);

    // Both sources valid continuously: db, resched, db, ...
    @(negedge clk);
    bus.db_qpn_valid  = 1'b1;
    bus.db_qpn_data   = 24'h123451;
    bus.resched_valid = 1'b1;
    bus.resched_qpn   = 24'h00ABC2;
    prev_qpn = '0;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("alt_dbrdy", bus.db_qpn_ready,    (k % 2 == 0) ? 1 : 0);
      check("alt_rsrdy", bus.resched_ready,   (k % 2 == 1) ? 1 : 0);
      check("alt_wen",   bus.on_schedule_wen, (k % 2 == 0) ? 1 : 0);
      if (k % 2 == 0) check("alt_addr", bus.on_schedule_addr, 1);
      check("alt_svld",  bus.sched_valid,     (k > 0) ? 1 : 0);
      if (k > 0) check("alt_sqpn", bus.sched_qpn, prev_qpn);
      prev_qpn = (k % 2 == 0) ? 24'h123451 : 24'h00ABC2;
      @(negedge clk);
    end
    bus.db_qpn_valid  = 1'b0;
    bus.resched_valid = 1'b0;
    #1;
    check("alt_last", bus.sched_qpn, 24'h00ABC2);
`ifdef SCHED_STAT_EN
    check("stat_db4", stat_db_cnt,      4);
    check("stat_rs4", stat_resched_cnt, 4);
    check("stat_nf",  stat_full_cyc,    0);
`endif
    @(negedge clk); bus.sched_ready = 1'b0; #1;
    check("alt_empty", bus.sched_valid, 0);

    // Fill 16 entries alternating sources with no dequeue
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      bus.db_qpn_valid  = 1'b1;
      bus.db_qpn_data   = 24'h000200 + 24'(i);
      bus.resched_valid = 1'b1;
      bus.resched_qpn   = 24'h000300 + 24'(i);
      #1;
      check("fill_dbrdy", bus.db_qpn_ready,  (i % 2 == 0) ? 1 : 0);
      check("fill_rsrdy", bus.resched_ready, (i % 2 == 1) ? 1 : 0);
      exp_q.push_back((i % 2 == 0) ? 24'h000200 + 24'(i) : 24'h000300 + 24'(i));
      @(negedge clk);
    end
    // Full: both readies stay low even while a dequeue happens
    bus.db_qpn_data = 24'h000210;
    bus.resched_qpn = 24'h000310;
    bus.sched_ready = 1'b1;
    #1;
    check("full_dbrdy", bus.db_qpn_ready,  0);
    check("full_rsrdy", bus.resched_ready, 0);
    check("full_svld",  bus.sched_valid,   1);
    head = exp_q.pop_front();
    check("full_head",  bus.sched_qpn,     head);
    @(negedge clk); bus.sched_ready = 1'b0; #1;
    check("refill_dbrdy", bus.db_qpn_ready,  1);
    check("refill_rsrdy", bus.resched_ready, 0);
    exp_q.push_back(24'h000210);
`ifdef SCHED_STAT_EN
    check("stat_full1", stat_full_cyc, 1);
`endif
    // Drain all 16, verifying FIFO order across the pointer wrap
    @(negedge clk);
    bus.db_qpn_valid  = 1'b0;
    bus.resched_valid = 1'b0;
    bus.sched_ready   = 1'b1;
    for (int j = 0; j < 16; j++) begin
      #1;
      check("drain_svld", bus.sched_valid, 1);
      head = exp_q.pop_front();
      check("drain_sqpn", bus.sched_qpn, head);
      @(negedge clk);
    end
    #1;
    check("drain_empty", bus.sched_valid, 0);

    // Doorbell grant and deschedule in the same cycle
    @(negedge clk);
    bus.sched_ready   = 1'b0;
    bus.db_qpn_valid  = 1'b1;
    bus.db_qpn_data   = 24'h000009;
    bus.desched_valid = 1'b1;
    bus.desched_qpn   = 24'hFFFFF3;
    #1;
    check("ds_dbrdy", bus.db_qpn_ready,     1);
    check("ds_block", bus.desched_ready,    0);
    check("ds_wen1",  bus.on_schedule_wen,  1);
    check("ds_addr1", bus.on_schedule_addr, 9);
    check("ds_din1",  bus.on_schedule_din,  1);
    @(negedge clk); bus.db_qpn_valid = 1'b0; bus.sched_ready = 1'b1; #1;
    check("ds_rdy",   bus.desched_ready,    1);
    check("ds_wen2",  bus.on_schedule_wen,  1);
    check("ds_addr2", bus.on_schedule_addr, 3);
    check("ds_din2",  bus.on_schedule_din,  0);
    check("ds_sqpn",  bus.sched_qpn,        24'h000009);
    @(negedge clk); bus.desched_valid = 1'b0; bus.sched_ready = 1'b0; #1;
    check("ds_idle",  bus.on_schedule_wen,  0);
    check("ds_empty", bus.sched_valid,      0);

    // Reset with 5 entries queued
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.db_qpn_valid = 1'b1;
      bus.db_qpn_data  = 24'h000040 + 24'(i);
      @(negedge clk);
    end
    bus.db_qpn_valid = 1'b0;
    #1;
    check("mr_svld_pre", bus.sched_valid, 1);
    check("mr_sqpn_pre", bus.sched_qpn,   24'h000040);
    #2;
    rst = 1'b0;
    #1;
    check("mr_svld", bus.sched_valid,      0);
    check("mr_sqpn", bus.sched_qpn,        0);
    check("mr_done", bus.init_done,        0);
    check("mr_wen",  bus.on_schedule_wen,  1);
    check("mr_addr", bus.on_schedule_addr, 0);
`ifdef SCHED_STAT_EN
    check("mr_stat_db",   stat_db_cnt,      0);
    check("mr_stat_rs",   stat_resched_cnt, 0);
    check("mr_stat_full", stat_full_cyc,    0);
`endif
    @(negedge clk); rst = 1'b1; #1;
    check_init();
    check("mr_post_svld", bus.sched_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
